// File: rtl/stc0_twsram_arbiter_if.sv
// Bundle between the twiddle SRAM arbiter and its two requesters plus the SRAM macro.
// The slave modport is the arbiter's view; master is the requester/SRAM side.
interface stc0_twsram_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 7
) ();
  logic          b_req;
  logic [AW-1:0] b_addr;
  logic          b_gnt;
  logic [DW-1:0] b_rdata;
  logic          b_rvalid;

  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic [DW-1:0] h_rdata;
  logic          h_rvalid;

  logic          cs_n;
  logic          we_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport slave (
    input  b_req, b_addr, h_req, h_we, h_addr, h_wdata, rdata,
    output b_gnt, b_rdata, b_rvalid, h_gnt, h_rdata, h_rvalid,
           cs_n, we_n, addr, wdata
  );

  modport master (
    output b_req, b_addr, h_req, h_we, h_addr, h_wdata, rdata,
    input  b_gnt, b_rdata, b_rvalid, h_gnt, h_rdata, h_rvalid,
           cs_n, we_n, addr, wdata
  );
endinterface

// File: rtl/stc0_twsram_arbiter.sv
// Twiddle SRAM arbiter: butterfly reads have priority, host load/readback is
// guaranteed a slot after STARVE_LIMIT consecutive denied cycles.
//
// state    | meaning
// BF_PRI   | butterfly wins a simultaneous request (default)
// HOST_PRI | host owed a turn; lasts one cycle, host wins if requesting
module stc0_twsram_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 7,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  stc0_twsram_arbiter_if.slave   bus
);
  typedef enum logic {BF_PRI, HOST_PRI} state_t;

  typedef struct packed {
    logic vld;
    logic host;
  } tag_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t        state_q, state_d;
  logic [7:0]    starve_q, starve_d;
  logic          b_gnt_c, h_gnt_c;
  logic          cs_n_q, we_n_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  tag_t          tag_q [0:RD_LAT];
  tag_t          ret;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    b_gnt_c  = 1'b0;
    h_gnt_c  = 1'b0;

    // No grant may leave the block in a reset cycle.
    if (!rst) begin
      case (state_q)
        BF_PRI: begin
          if (bus.b_req)      b_gnt_c = 1'b1;
          else if (bus.h_req) h_gnt_c = 1'b1;
        end
        HOST_PRI: begin
          if (bus.h_req)      h_gnt_c = 1'b1;
          else if (bus.b_req) b_gnt_c = 1'b1;
        end
        default: ;
      endcase
    end

    if (!bus.h_req || h_gnt_c)
      starve_d = 8'd0;
    else if (starve_q != LIMIT)
      starve_d = starve_q + 8'd1;

    case (state_q)
      BF_PRI:   if (starve_d == LIMIT) state_d = HOST_PRI;
      HOST_PRI: state_d = BF_PRI;
      default:  state_d = BF_PRI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BF_PRI;
      starve_q <= 8'd0;
      cs_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cs_n_q   <= ~(b_gnt_c | h_gnt_c);
      we_n_q   <= ~(h_gnt_c & bus.h_we);
      if (b_gnt_c)      addr_q <= bus.b_addr;
      else if (h_gnt_c) addr_q <= bus.h_addr;
      if (h_gnt_c && bus.h_we) wdata_q <= bus.h_wdata;
      // Tag pipe tracks which requester owns each read until its data lands.
      tag_q[0] <= '{vld: b_gnt_c | (h_gnt_c & ~bus.h_we), host: h_gnt_c};
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign ret          = tag_q[RD_LAT];
  assign bus.b_gnt    = b_gnt_c;
  assign bus.h_gnt    = h_gnt_c;
  assign bus.cs_n     = cs_n_q;
  assign bus.we_n     = we_n_q;
  assign bus.addr     = addr_q;
  assign bus.wdata    = wdata_q;
  assign bus.b_rvalid = ~rst & ret.vld & ~ret.host;
  assign bus.h_rvalid = ~rst & ret.vld & ret.host;
  assign bus.b_rdata  = bus.b_rvalid ? bus.rdata : '0;
  assign bus.h_rdata  = bus.h_rvalid ? bus.rdata : '0;
endmodule
